// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared FSM state encodings and mode constants for stream_demux_n.
package stream_demux_pkg;
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
    localparam logic [1:0] DROP   = 2'd2;
endpackage

// File: rtl/stream_demux_if.sv
// stream_demux_if: producer-side and per-channel consumer-side stream signals of the demux.
interface stream_demux_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT)
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     in_last;
    logic [SEL_W-1:0]         in_sel;
    logic                     mode;
    logic [N_OUT-1:0]         out_valid;
    logic [N_OUT-1:0]         out_ready;
    logic [N_OUT*DATA_W-1:0]  out_data;
    logic [N_OUT-1:0]         out_last;
    logic                     err_sel;
    modport master (
        output in_valid, in_data, in_last, in_sel, mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, err_sel
    );
    modport slave (
        input  in_valid, in_data, in_last, in_sel, mode, out_ready,
        output in_ready, out_valid, out_data, out_last, err_sel
    );
endinterface

// File: rtl/stream_demux_out_slot.sv
// demux_out_slot: one-entry output register; payload reads zero whenever the slot is empty.
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              pop,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              full,
    output logic [DATA_W-1:0] data,
    output logic              last
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
            last <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= in_data;
            last <= in_last;
        end else if (pop) begin
            full <= 1'b0;
            data <= '0;
            last <= 1'b0;
        end
    end
endmodule

// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N stream demux with packet locking, select or round-robin routing.
module stream_demux_n
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input logic           clk,
    input logic           rst_n,
    stream_demux_if.slave bus
);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_OUT - 1);
    logic [1:0]              state;
    logic [SEL_W-1:0]        rr_ptr, tgt_q, target;
    logic                    mode_q, rr_mode, sel_bad, acc, route, err_q;
    logic [N_OUT-1:0]        load, pop, vld, lst;
    logic [N_OUT*DATA_W-1:0] dat;

    assign sel_bad = state == IDLE && bus.mode == MODE_SEL && bus.in_sel > LAST_CH;
    assign target  = state == LOCKED ? tgt_q : (bus.mode == MODE_RR ? rr_ptr : bus.in_sel);
    assign rr_mode = state == IDLE ? bus.mode : mode_q;
    // Out-of-range target only occurs under sel_bad or DROP, both of which force ready high.
    assign bus.in_ready = state == DROP || sel_bad || !vld[target] || bus.out_ready[target];
    assign acc   = bus.in_valid && bus.in_ready;
    assign route = acc && state != DROP && !sel_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            tgt_q  <= '0;
            mode_q <= MODE_SEL;
            err_q  <= 1'b0;
        end else begin
            err_q <= acc && sel_bad;
            if (route && bus.in_last && rr_mode == MODE_RR)
                rr_ptr <= rr_ptr == LAST_CH ? '0 : rr_ptr + 1'b1;
            if (acc && bus.in_last)
                state <= IDLE;
            else if (acc && state == IDLE)
                state <= sel_bad ? DROP : LOCKED;
            if (acc && state == IDLE) begin
                tgt_q  <= target;
                mode_q <= bus.mode;
            end
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign load[k] = route && target == SEL_W'(k);
        assign pop[k]  = vld[k] && bus.out_ready[k];
        demux_out_slot #(.DATA_W(DATA_W)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .pop     (pop[k]),
            .in_data (bus.in_data),
            .in_last (bus.in_last),
            .full    (vld[k]),
            .data    (dat[k*DATA_W +: DATA_W]),
            .last    (lst[k])
        );
    end

    assign bus.out_valid = vld;
    assign bus.out_data  = dat;
    assign bus.out_last  = lst;
    assign bus.err_sel   = err_q;
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: directed checks of an 8-channel and a 6-channel demux instance.
module tb_stream_demux_n;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    stream_demux_if #(.DATA_W(8), .N_OUT(8)) b8 ();
    stream_demux_if #(.DATA_W(8), .N_OUT(6)) b6 ();

    stream_demux_n #(.DATA_W(8), .N_OUT(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    stream_demux_n #(.DATA_W(8), .N_OUT(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic put8(input logic v, input logic [2:0] s, input logic [7:0] d, input logic l);
        b8.in_valid = v;
        b8.in_sel   = s;
        b8.in_data  = d;
        b8.in_last  = l;
    endtask

    task automatic put6(input logic v, input logic [2:0] s, input logic [7:0] d, input logic l);
        b6.in_valid = v;
        b6.in_sel   = s;
        b6.in_data  = d;
        b6.in_last  = l;
    endtask

    function automatic logic [63:0] at(input int k, input logic [7:0] d);
        return 64'(d) << (8 * k);
    endfunction

    initial begin
        put8(0, 0, 0, 0);
        put6(0, 0, 0, 0);
        b8.mode = 0;
        b6.mode = 0;
        b8.out_ready = '1;
        b6.out_ready = '1;
        repeat (2) tick;
        chk("rst_valid", b8.out_valid, 0);
        chk("rst_data", b8.out_data, 0);
        chk("rst_err", b8.err_sel, 0);
        chk("rst6_valid", b6.out_valid, 0);
        rst_n = 1'b1;
        // explicit select, 3-beat packet to ch5
        tick;
        put8(1, 5, 8'hA1, 0);
        #1 chk("m0_rdy", b8.in_ready, 1);
        tick;
        chk("m0_v1", b8.out_valid, 8'h20);
        chk("m0_d1", b8.out_data, at(5, 8'hA1));
        chk("m0_l1", b8.out_last, 0);
        put8(1, 5, 8'hA2, 0);
        tick;
        chk("m0_v2", b8.out_valid, 8'h20);
        chk("m0_d2", b8.out_data, at(5, 8'hA2));
        put8(1, 5, 8'hA3, 1);
        tick;
        chk("m0_v3", b8.out_valid, 8'h20);
        chk("m0_d3", b8.out_data, at(5, 8'hA3));
        chk("m0_l3", b8.out_last, 8'h20);
        put8(0, 0, 0, 0);
        tick;
        chk("m0_empty_v", b8.out_valid, 0);
        chk("m0_empty_d", b8.out_data, 0);
        // packet lock: in_sel changes mid-packet
        put8(1, 5, 8'hB1, 0);
        tick;
        chk("lock_v1", b8.out_valid, 8'h20);
        put8(1, 2, 8'hB2, 1);
        tick;
        chk("lock_v2", b8.out_valid, 8'h20);
        chk("lock_d2", b8.out_data, at(5, 8'hB2));
        put8(1, 2, 8'hC1, 1);
        tick;
        chk("lock_next_v", b8.out_valid, 8'h04);
        chk("lock_next_d", b8.out_data, at(2, 8'hC1));
        put8(0, 0, 0, 0);
        tick;
        // backpressure on ch1
        b8.out_ready = 8'hFD;
        put8(1, 1, 8'h11, 1);
        #1 chk("bp_rdy1", b8.in_ready, 1);
        tick;
        chk("bp_v1", b8.out_valid, 8'h02);
        chk("bp_d1", b8.out_data, at(1, 8'h11));
        put8(1, 1, 8'h12, 1);
        #1 chk("bp_stall", b8.in_ready, 0);
        put8(1, 4, 8'h44, 1);
        #1 chk("bp_other_rdy", b8.in_ready, 1);
        tick;
        chk("bp_v2", b8.out_valid, 8'h12);
        chk("bp_d2", b8.out_data, at(1, 8'h11) | at(4, 8'h44));
        put8(0, 0, 0, 0);
        tick;
        chk("bp_v3", b8.out_valid, 8'h02);
        chk("bp_hold", b8.out_data, at(1, 8'h11));
        b8.out_ready = '1;
        put8(1, 1, 8'h12, 1);
        #1 chk("bp_rdy_pop", b8.in_ready, 1);
        tick;
        chk("bp_popload_v", b8.out_valid, 8'h02);
        chk("bp_popload_d", b8.out_data, at(1, 8'h12));
        put8(0, 0, 0, 0);
        tick;
        chk("bp_drain", b8.out_valid, 0);
        // round-robin: 9 single beats wrap 0..7,0
        b8.mode = 1;
        for (int i = 0; i < 9; i++) begin
            put8(1, 7, 8'h50 + 8'(i), 1);
            tick;
            chk($sformatf("rr_v%0d", i), b8.out_valid, 64'(8'h01 << (i % 8)));
            chk($sformatf("rr_d%0d", i), b8.out_data, at(i % 8, 8'h50 + 8'(i)));
        end
        // 2-beat packet stays on ch1 even if mode/in_sel change mid-packet
        put8(1, 3, 8'hD1, 0);
        tick;
        chk("rr_pkt_v1", b8.out_valid, 8'h02);
        b8.mode = 0;
        put8(1, 6, 8'hD2, 1);
        tick;
        chk("rr_pkt_v2", b8.out_valid, 8'h02);
        chk("rr_pkt_d2", b8.out_data, at(1, 8'hD2));
        b8.mode = 1;
        put8(1, 0, 8'hD3, 1);
        tick;
        chk("rr_after_pkt", b8.out_valid, 8'h04);
        put8(0, 0, 0, 0);
        tick;
        // reset mid-packet with ch3 stalled full
        b8.mode = 0;
        b8.out_ready = 8'hF7;
        put8(1, 3, 8'hE1, 0);
        tick;
        chk("mid_v", b8.out_valid, 8'h08);
        put8(1, 3, 8'hE2, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", b8.out_valid, 0);
        chk("mid_rst_d", b8.out_data, 0);
        chk("mid_rst_l", b8.out_last, 0);
        put8(0, 0, 0, 0);
        tick;
        rst_n = 1'b1;
        b8.out_ready = '1;
        b8.mode = 1;
        put8(1, 5, 8'hF0, 1);
        tick;
        chk("post_rst_v", b8.out_valid, 8'h01);
        chk("post_rst_d", b8.out_data, at(0, 8'hF0));
        put8(0, 0, 0, 0);
        tick;
        // N_OUT=6: invalid select drops the whole packet
        put6(1, 7, 8'h61, 0);
        #1 chk("n6_rdy1", b6.in_ready, 1);
        tick;
        chk("n6_v1", b6.out_valid, 0);
        chk("n6_err1", b6.err_sel, 1);
        put6(1, 7, 8'h62, 1);
        #1 chk("n6_rdy2", b6.in_ready, 1);
        tick;
        chk("n6_v2", b6.out_valid, 0);
        chk("n6_err2", b6.err_sel, 0);
        put6(1, 1, 8'h71, 1);
        #1 chk("n6_rdy3", b6.in_ready, 1);
        tick;
        chk("n6_v3", b6.out_valid, 6'h02);
        chk("n6_d3", b6.out_data, at(1, 8'h71));
        chk("n6_err3", b6.err_sel, 0);
        put6(0, 0, 0, 0);
        tick;
        chk("n6_drain", b6.out_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
